pipeline_stall_controller: RTL

Central sequencer for stall, flush and freeze control in the 5-stage pipeline. It combines the ID-stage load-use hazard request, the EX-stage taken-branch redirect and the MEM-stage data-memory wait into one prioritised set of write-enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also adds three functions the combinational hazard logic does not cover:
- a post-reset drain sequence;
- a bounded memory-wait watchdog with halt;
- saturating stall and flush performance counters.

---
 rtl/pipeline_stall_if.sv | 34 +++
 rtl/pipeline_stall_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_if.sv
// Hazard requests into the stall controller and the pipeline-register
// control it produces.
interface pipeline_stall_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_use_hazard;
  logic             branch_taken_EX;
  logic             mem_req_EXMEM;
  logic             mem_ready;
  logic             PC_write;
  logic             IFID_write;
  logic             IDEX_write;
  logic             EXMEM_write;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             MEMWB_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output load_use_hazard, branch_taken_EX, mem_req_EXMEM, mem_ready,
    input  PC_write, IFID_write, IDEX_write, EXMEM_write,
    input  IFID_flush, IDEX_flush, MEMWB_bubble, halted,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  load_use_hazard, branch_taken_EX, mem_req_EXMEM, mem_ready,
    output PC_write, IFID_write, IDEX_write, EXMEM_write,
    output IFID_flush, IDEX_flush, MEMWB_bubble, halted,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/flush/freeze sequencer for the 5-stage pipeline with
// post-reset drain, memory-wait watchdog and saturating perf counters.
module pipeline_stall_controller #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_stall_if.slave  bus
);
  localparam int unsigned INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INIT_W-1:0]   r_init_cnt;
  logic [INIT_W-1:0]   w_init_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_count;

  logic w_hold;
  logic w_flow;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_write;
  logic w_exmem_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_memwb_bubble;
  logic w_halted;

  assign w_hold = bus.mem_req_EXMEM & ~bus.mem_ready;

  // State, drain/wait counters and saturating perf counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_INIT;
      r_init_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall_inc && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush_inc && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  // Next state and control decode; w_flow selects the normal RUN priorities
  always_comb begin
    w_state_nxt    = r_state;
    w_init_nxt     = r_init_cnt;
    w_wait_nxt     = r_wait_cnt;
    w_flow         = 1'b0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    w_pc_write     = 1'b0;
    w_ifid_write   = 1'b0;
    w_idex_write   = 1'b0;
    w_exmem_write  = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_memwb_bubble = 1'b0;
    w_halted       = 1'b0;

    unique case (r_state)
      S_INIT: begin
        w_ifid_flush   = 1'b1;
        w_idex_flush   = 1'b1;
        w_memwb_bubble = 1'b1;
        if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_state_nxt = S_RUN;
        else                                         w_init_nxt  = r_init_cnt + INIT_W'(1);
      end
      S_RUN: begin
        if (w_hold) begin
          w_memwb_bubble = 1'b1;
          w_stall_inc    = 1'b1;
          w_wait_nxt     = WAIT_W'(1);
          w_state_nxt    = S_MEM_WAIT;
        end else begin
          w_flow = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (w_hold) begin
          w_memwb_bubble = 1'b1;
          w_stall_inc    = 1'b1;
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) w_state_nxt = S_HALT;
          else                                         w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end else begin
          w_flow      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_HALT: begin
        w_memwb_bubble = 1'b1;
        w_halted       = 1'b1;
      end
      default: w_state_nxt = S_INIT;
    endcase

    if (w_flow) begin
      w_pc_write    = 1'b1;
      w_ifid_write  = 1'b1;
      w_idex_write  = 1'b1;
      w_exmem_write = 1'b1;
      if (bus.branch_taken_EX) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        w_flush_inc  = 1'b1;
      end else if (bus.load_use_hazard) begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_idex_flush = 1'b1;
        w_stall_inc  = 1'b1;
      end
    end

    // Reset held high looks like INIT to the pipeline
    if (reset) begin
      w_pc_write     = 1'b0;
      w_ifid_write   = 1'b0;
      w_idex_write   = 1'b0;
      w_exmem_write  = 1'b0;
      w_ifid_flush   = 1'b1;
      w_idex_flush   = 1'b1;
      w_memwb_bubble = 1'b1;
      w_halted       = 1'b0;
    end
  end

  assign bus.PC_write     = w_pc_write;
  assign bus.IFID_write   = w_ifid_write;
  assign bus.IDEX_write   = w_idex_write;
  assign bus.EXMEM_write  = w_exmem_write;
  assign bus.IFID_flush   = w_ifid_flush;
  assign bus.IDEX_flush   = w_idex_flush;
  assign bus.MEMWB_bubble = w_memwb_bubble;
  assign bus.halted       = w_halted;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule
